// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a program-loader port share one
// single-port word memory. One access per SERVE cycle, ties broken against
// the port served last, acks are one-cycle pulses the cycle after service.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,
    output logic        mem_we,
    output logic [15:0] mem_a,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_spo,
    output logic        busy,
    output logic [15:0] cpu_cnt,
    output logic [15:0] ld_cnt
);

    typedef enum logic [1:0] {IDLE, SERVE_CPU, SERVE_LD} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        acc_we_q, acc_we_d;
    logic [15:0] acc_a_q, acc_a_d;
    logic [31:0] acc_d_q, acc_d_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic [31:0] cpu_rd_q, cpu_rd_d;
    logic [31:0] ld_rd_q, ld_rd_d;
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] ld_cnt_q, ld_cnt_d;
    logic        cpu_elig, ld_elig;

    // Byte-offset and upper address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{cpu_addr[31:18], cpu_addr[1:0], ld_addr[31:18], ld_addr[1:0]};

    // A port currently being served is not eligible again: its ack is
    // already on the way, so its still-high req belongs to this access.
    assign cpu_elig = cpu_req && !cpu_ack_q && (state_q != SERVE_CPU);
    assign ld_elig  = ld_req  && !ld_ack_q  && (state_q != SERVE_LD);

    assign busy      = (state_q != IDLE);
    assign mem_we    = acc_we_q && busy && !reset;
    assign mem_a     = acc_a_q;
    assign mem_d     = acc_d_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign cpu_rdata = cpu_rd_q;
    assign ld_rdata  = ld_rd_q;
    assign cpu_cnt   = cpu_cnt_q;
    assign ld_cnt    = ld_cnt_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;

    // Next-state arbitration, access latch on SERVE entry, ack/rdata/count
    // update at the end of each SERVE cycle.
    always_comb begin
        state_d   = IDLE;
        last_d    = last_q;
        acc_we_d  = acc_we_q;
        acc_a_d   = acc_a_q;
        acc_d_d   = acc_d_q;
        cpu_ack_d = 1'b0;
        ld_ack_d  = 1'b0;
        cpu_rd_d  = cpu_rd_q;
        ld_rd_d   = ld_rd_q;
        cpu_cnt_d = cpu_cnt_q;
        ld_cnt_d  = ld_cnt_q;

        unique case ({cpu_elig, ld_elig})
            2'b10:   state_d = SERVE_CPU;
            2'b01:   state_d = SERVE_LD;
            2'b11:   state_d = (last_q == PORT_LD) ? SERVE_CPU : SERVE_LD;
            default: state_d = IDLE;
        endcase

        if (state_d == SERVE_CPU) begin
            last_d   = PORT_CPU;
            acc_we_d = cpu_we;
            acc_a_d  = cpu_addr[17:2];
            acc_d_d  = cpu_wdata;
        end else if (state_d == SERVE_LD) begin
            last_d   = PORT_LD;
            acc_we_d = ld_we;
            acc_a_d  = ld_addr[17:2];
            acc_d_d  = ld_wdata;
        end

        if (state_q == SERVE_CPU) begin
            cpu_ack_d = 1'b1;
            if (!acc_we_q) cpu_rd_d = mem_spo;
            if (cpu_cnt_q != 16'hFFFF) cpu_cnt_d = cpu_cnt_q + 16'd1;
        end else if (state_q == SERVE_LD) begin
            ld_ack_d = 1'b1;
            if (!acc_we_q) ld_rd_d = mem_spo;
            if (ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
        end
    end

    // State and datapath registers; reset aborts any in-flight access unacked.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= PORT_LD;
            acc_we_q  <= 1'b0;
            acc_a_q   <= 16'h0;
            acc_d_q   <= 32'h0;
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            cpu_rd_q  <= 32'h0;
            ld_rd_q   <= 32'h0;
            cpu_cnt_q <= 16'h0;
            ld_cnt_q  <= 16'h0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            acc_we_q  <= acc_we_d;
            acc_a_q   <= acc_a_d;
            acc_d_q   <= acc_d_d;
            cpu_ack_q <= cpu_ack_d;
            ld_ack_q  <= ld_ack_d;
            cpu_rd_q  <= cpu_rd_d;
            ld_rd_q   <= ld_rd_d;
            cpu_cnt_q <= cpu_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single accesses checked through an
// ack scoreboard, plus hand sequences for latency, contention and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_ack, ld_ack, cpu_stall, mem_we, busy;
    logic [31:0] cpu_rdata, ld_rdata, mem_d, mem_spo;
    logic [15:0] mem_a, cpu_cnt, ld_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_spo(mem_spo),
        .busy(busy), .cpu_cnt(cpu_cnt), .ld_cnt(ld_cnt)
    );

    // Single-port word memory with combinational read
    logic [31:0] mem [0:65535];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
    assign mem_spo = mem[mem_a];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic [15:0] cnt;
    } sb_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    sb_t         sb[$];
    logic        g_port[$];
    int          g_cyc[$];
    vec_t        vecs[8];
    int          n_chk = 0, n_pass = 0;
    logic        sb_en = 1'b0;
    logic        both_ack = 1'b0;
    int          we_cnt = 0;
    logic [15:0] we_addr = 16'h0;
    logic [15:0] exp_cnt [2];
    logic [31:0] last_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic ack_event(input logic port, input logic [31:0] rd, input logic [15:0] cnt);
        sb_t e;
        g_port.push_back(port);
        g_cyc.push_back(cyc);
        if (sb_en) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected_ack: port %0d acked with nothing pending", port);
            end else begin
                e = sb.pop_front();
                chk("sb_port", {31'b0, port}, {31'b0, e.port});
                chk("sb_rdata", rd, e.rd);
                chk("sb_cnt", {16'b0, cnt}, {16'b0, e.cnt});
            end
        end
    endtask

    // Ack monitor: feeds the scoreboard and grant log
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_ack && ld_ack) both_ack = 1'b1;
            if (cpu_ack) ack_event(1'b0, cpu_rdata, cpu_cnt);
            if (ld_ack)  ack_event(1'b1, ld_rdata, ld_cnt);
            if (mem_we) begin we_cnt++; we_addr = mem_a; end
        end
    end

    task automatic model_reset();
        exp_cnt[0] = 16'h0; exp_cnt[1] = 16'h0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    endtask

    task automatic expect_ack(input logic port, input logic we, input logic [31:0] rd);
        sb_t e;
        if (!we) last_rd[port] = rd;
        if (exp_cnt[port] != 16'hFFFF) exp_cnt[port] = exp_cnt[port] + 16'd1;
        e.port = port; e.rd = last_rd[port]; e.cnt = exp_cnt[port];
        sb.push_back(e);
    endtask

    // One access on one port, called just after a negedge; checks 2-cycle latency
    task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
        int n = -1;
        expect_ack(port, we, exp_rd);
        if (port) begin ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wdata; end
        else begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port ? ld_ack : cpu_ack) === 1'b1) begin n = i + 1; break; end
        end
        chk("latency", n, 2);
        cpu_req = 0; ld_req = 0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tc, tl, bad, maxgap, last_c, last_l, d;
        logic [31:0] old;

        vecs[0] = '{1'b0, 1'b1, 32'hFFFC0008, 32'hA5A5A5A5, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h00000008, 32'h0,        32'hA5A5A5A5};
        vecs[2] = '{1'b1, 1'b0, 32'h00000014, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h0003FFFC, 32'h0BADF00D, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0003FFFF, 32'h0,        32'h0BADF00D};
        vecs[5] = '{1'b1, 1'b1, 32'h00000000, 32'h11112222, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h00000001, 32'h0,        32'h11112222};
        vecs[7] = '{1'b0, 1'b0, 32'h00000040, 32'h0,        32'h12345678};

        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", {31'b0, cpu_ack}, 0);
        chk("rst_ld_ack", {31'b0, ld_ack}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_a", {16'b0, mem_a}, 0);
        chk("rst_cnts", {cpu_cnt, ld_cnt}, 0);
        chk("rst_rdata", cpu_rdata | ld_rdata, 0);
        reset = 0;
        sb_en = 1;
        @(negedge clk);

        // Preload word 5 through the loader
        do_access(1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 32'h0);

        // Single CPU read, checked cycle by cycle
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
        #1 chk("stall_wait", {31'b0, cpu_stall}, 1);
        @(negedge clk);
        chk("rd_mem_a", {16'b0, mem_a}, 5);
        chk("rd_busy", {31'b0, busy}, 1);
        chk("rd_mem_we", {31'b0, mem_we}, 0);
        chk("rd_ack_early", {31'b0, cpu_ack}, 0);
        @(negedge clk);
        chk("rd_ack", {31'b0, cpu_ack}, 1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_cnt", {16'b0, cpu_cnt}, 1);
        chk("stall_at_ack", {31'b0, cpu_stall}, 0);
        cpu_req = 0;
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, cpu_ack}, 0);

        // Loader write then CPU read of an unaligned alias
        we_cnt = 0;
        do_access(1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0);
        chk("ldw_we_cycles", we_cnt, 1);
        chk("ldw_we_addr", {16'b0, we_addr}, 16);
        do_access(1'b0, 1'b0, 32'h43, 32'h0, 32'h12345678);

        for (int i = 0; i < 8; i++)
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Simultaneous requests right after reset: CPU first, then loader
        reset = 1; @(negedge clk); reset = 0;
        model_reset(); sb.delete();
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
        expect_ack(1'b1, 1'b0, 32'h12345678);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
        ld_req = 1; ld_we = 0; ld_addr = 32'h40;
        t0 = cyc; tc = -1; tl = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("sim_first_a", {16'b0, mem_a}, 5);
            if (i == 1) chk("sim_second_a", {16'b0, mem_a}, 16);
            if (cpu_ack) begin tc = cyc - t0; cpu_req = 0; end
            if (ld_ack) begin tl = cyc - t0; ld_req = 0; end
        end
        chk("sim_cpu_ack_cyc", tc, 2);
        chk("sim_ld_ack_cyc", tl, 3);

        // Sustained contention: both ports hold req high
        sb_en = 0;
        g_port.delete(); g_cyc.delete();
        cpu_req = 1; ld_req = 1;
        t0 = cyc;
        repeat (20) @(negedge clk);
        cpu_req = 0; ld_req = 0;
        repeat (3) @(negedge clk);
        bad = 0; maxgap = 0; last_c = t0; last_l = t0;
        for (int i = 0; i < g_port.size(); i++) begin
            if (i > 0 && g_port[i] == g_port[i-1]) bad++;
            d = g_cyc[i] - (g_port[i] ? last_l : last_c);
            if (d > maxgap) maxgap = d;
            if (g_port[i]) last_l = g_cyc[i]; else last_c = g_cyc[i];
        end
        chk("cont_grants_ge10", {31'b0, g_port.size() >= 10}, 1);
        chk("cont_first_cpu", {31'b0, g_port[0]}, 0);
        chk("cont_alternate", bad, 0);
        chk("cont_wait_bound", {31'b0, maxgap <= 4}, 1);
        d = int'(cpu_cnt) - int'(ld_cnt);
        chk("cont_cnt_diff", {31'b0, d >= -1 && d <= 1}, 1);

        // Reset during a loader write
        old = mem[32];
        ld_req = 1; ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rw_we_before", {31'b0, mem_we}, 1);
        reset = 1;
        #1 chk("rw_we_suppressed", {31'b0, mem_we}, 0);
        @(negedge clk);
        chk("rw_no_ack", {31'b0, ld_ack}, 0);
        chk("rw_idle", {31'b0, busy}, 0);
        chk("rw_mem_a", {16'b0, mem_a}, 0);
        chk("rw_mem_d", mem_d, 0);
        chk("rw_cnts", {cpu_cnt, ld_cnt}, 0);
        chk("rw_rdata", cpu_rdata | ld_rdata, 0);
        chk("rw_mem_unchanged", mem[32], old);
        ld_req = 0; ld_we = 0; reset = 0;
        @(negedge clk);
        chk("rw_no_late_ack", {31'b0, ld_ack}, 0);

        // Counter saturation
        model_reset(); sb.delete(); sb_en = 1;
        force dut.cpu_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cpu_cnt_q;
        exp_cnt[0] = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_access(1'b0, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF);
        chk("sat_cnt", {16'b0, cpu_cnt}, 32'h0000FFFF);

        chk("never_both_acks", {31'b0, both_ack}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
